// File: rtl/ip_sequencer_if.sv
// Bus bundle between the instruction sequencer and its I register, memory and execute unit.
interface ip_sequencer_if;
  logic [11:0] I;
  logic [1:0]  I_F;
  logic [11:0] I_In;
  logic        regP;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic        op_valid;
  logic [2:0]  slot_op;
  logic        exec_done;
  logic        branch_take;
  logic [11:0] branch_target;
  logic        arg_req;
  logic        arg_valid;
  logic [11:0] arg_data;
  logic        halt;
  logic [2:0]  seq_state;

  modport master (
    input  I, mem_ack, mem_rdata, exec_done, branch_take, branch_target, arg_req, halt,
    output I_F, I_In, regP, mem_req, mem_addr, op_valid, slot_op, arg_valid, arg_data, seq_state
  );

  modport slave (
    output I, mem_ack, mem_rdata, exec_done, branch_take, branch_target, arg_req, halt,
    input  I_F, I_In, regP, mem_req, mem_addr, op_valid, slot_op, arg_valid, arg_data, seq_state
  );
endinterface

// File: rtl/ip_sequencer.sv
// Fetches 12-bit words of four 3-bit opcode slots and issues them to execute, with operand fetch and halt.
// Optional build macro SEQ_ZERO_SKIP_EN: end the word early once all remaining slots are zero.
module ip_sequencer #(
  parameter int BOOT_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ip_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_ARG   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q;
  logic [11:0] ir_q;
  logic [1:0]  slot_q;
  logic [3:0]  cnt_q;
  logic [11:0] arg_data_q;
  logic        arg_valid_q;
  logic        arg_done_q;

  logic [2:0]  cur_op;
  logic        last_slot;
  logic [1:0]  i_f_d;
  logic [11:0] i_in_d;
  logic        mem_req;

  always_comb begin
    cur_op = ir_q[2:0];
    case (slot_q)
      2'd0:    cur_op = ir_q[11:9];
      2'd1:    cur_op = ir_q[8:6];
      2'd2:    cur_op = ir_q[5:3];
      default: cur_op = ir_q[2:0];
    endcase
  end

`ifdef SEQ_ZERO_SKIP_EN
  logic rest_zero;

  // True when every slot after the current one holds opcode 000.
  always_comb begin
    rest_zero = 1'b1;
    case (slot_q)
      2'd0:    rest_zero = (ir_q[8:0] == 9'd0);
      2'd1:    rest_zero = (ir_q[5:0] == 6'd0);
      2'd2:    rest_zero = (ir_q[2:0] == 3'd0);
      default: rest_zero = 1'b1;
    endcase
  end

  assign last_slot = (slot_q == 2'd3) || rest_zero;
`else
  assign last_slot = (slot_q == 2'd3);
`endif

  // I register control must react to ack/exec_done within the same cycle.
  always_comb begin
    i_f_d  = 2'b00;
    i_in_d = 12'd0;
    case (state_q)
      S_FETCH, S_ARG: if (bus.mem_ack) i_f_d = 2'b01;
      S_ISSUE: begin
        if (bus.exec_done && bus.branch_take) begin
          i_f_d  = 2'b10;
          i_in_d = bus.branch_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= 12'd0;
      slot_q      <= 2'd0;
      cnt_q       <= 4'd0;
      arg_data_q  <= 12'd0;
      arg_valid_q <= 1'b0;
      arg_done_q  <= 1'b0;
    end else begin
      arg_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cnt_q == 4'(BOOT_DELAY - 1)) state_q <= bus.halt ? S_HALT : S_FETCH;
          else                             cnt_q   <= cnt_q + 4'd1;
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            ir_q       <= bus.mem_rdata;
            slot_q     <= 2'd0;
            arg_done_q <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // exec_done outranks arg_req; halt is only honoured at a word boundary.
          if (bus.exec_done) begin
            if (bus.branch_take || last_slot) begin
              state_q <= bus.halt ? S_HALT : S_FETCH;
            end else begin
              slot_q     <= slot_q + 2'd1;
              arg_done_q <= 1'b0;
            end
          end else if (bus.arg_req && !arg_done_q) begin
            state_q <= S_ARG;
          end
        end
        S_ARG: begin
          if (bus.mem_ack) begin
            arg_data_q  <= bus.mem_rdata;
            arg_valid_q <= 1'b1;
            arg_done_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_HALT: begin
          if (!bus.halt) state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req       = (state_q == S_FETCH) || (state_q == S_ARG);
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_req ? bus.I : 12'd0;
  assign bus.op_valid  = (state_q == S_ISSUE);
  assign bus.slot_op   = (state_q == S_ISSUE) ? cur_op : 3'd0;
  assign bus.regP      = (state_q == S_HALT);
  assign bus.I_F       = i_f_d;
  assign bus.I_In      = i_in_d;
  assign bus.arg_valid = arg_valid_q;
  assign bus.arg_data  = arg_data_q;
  assign bus.seq_state = state_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed table-driven bench for ip_sequencer: boot, fetch, issue, branch, operand, halt, zero slots, reset in ARG.
module tb_ip_sequencer;

  logic clk;
  logic rst_n;

  ip_sequencer_if bus ();

  ip_sequencer #(.BOOT_DELAY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [11:0] i;
    logic        ack;
    logic [11:0] rd;
    logic        done;
    logic        br;
    logic [11:0] tg;
    logic        areq;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        mreq;
    logic [11:0] maddr;
    logic [1:0]  i_f;
    logic [11:0] i_in;
    logic        regp;
    logic        opv;
    logic [2:0]  op;
    logic        argv;
    logic [11:0] argd;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_vec;
  int    n_bad;
  int    split;

  task automatic add(input string nm, input logic r, input logic [11:0] i, input logic ack,
                     input logic [11:0] rd, input logic d, input logic br, input logic [11:0] tg,
                     input logic a, input logic h, input logic [2:0] st, input logic m,
                     input logic [11:0] ad, input logic [1:0] f, input logic [11:0] iin,
                     input logic p, input logic v, input logic [2:0] o, input logic av,
                     input logic [11:0] argd);
    vec_t x;
    x.in  = '{rst: r, i: i, ack: ack, rd: rd, done: d, br: br, tg: tg, areq: a, halt: h};
    x.exp = '{st: st, mreq: m, maddr: ad, i_f: f, i_in: iin, regp: p, opv: v, op: o, argv: av, argd: argd};
    vecs.push_back(x);
    names.push_back(nm);
  endtask

  function automatic out_t sample();
    out_t s;
    s = '{st: bus.seq_state, mreq: bus.mem_req, maddr: bus.mem_addr, i_f: bus.I_F,
          i_in: bus.I_In, regp: bus.regP, opv: bus.op_valid, op: bus.slot_op,
          argv: bus.arg_valid, argd: bus.arg_data};
    return s;
  endfunction

  task automatic check(input string nm, input out_t exp);
    out_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d req=%b addr=%o I_F=%b I_In=%o regP=%b opv=%b op=%0d argv=%b argd=%o, expected st=%0d req=%b addr=%o I_F=%b I_In=%o regP=%b opv=%b op=%0d argv=%b argd=%o",
               nm, act.st, act.mreq, act.maddr, act.i_f, act.i_in, act.regp, act.opv, act.op, act.argv, act.argd,
               exp.st, exp.mreq, exp.maddr, exp.i_f, exp.i_in, exp.regp, exp.opv, exp.op, exp.argv, exp.argd);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      @(negedge clk);
      rst_n             = vecs[k].in.rst;
      bus.I             = vecs[k].in.i;
      bus.mem_ack       = vecs[k].in.ack;
      bus.mem_rdata     = vecs[k].in.rd;
      bus.exec_done     = vecs[k].in.done;
      bus.branch_take   = vecs[k].in.br;
      bus.branch_target = vecs[k].in.tg;
      bus.arg_req       = vecs[k].in.areq;
      bus.halt          = vecs[k].in.halt;
      #2;
      check(names[k], vecs[k].exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.I = 12'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 12'd0; bus.exec_done = 1'b0;
    bus.branch_take = 1'b0; bus.branch_target = 12'd0; bus.arg_req = 1'b0; bus.halt = 1'b0;

    //   name            rst I       ack rdata    dn br tgt     ar hl | st req addr    I_F   I_In    P  V  op av argd
    add("rst",           0, 12'o100, 0, 12'o0,    0, 0, 12'o0,   0, 0,  0, 0, 12'o0,   2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("idle",          1, 12'o100, 0, 12'o0,    0, 0, 12'o0,   0, 0,  0, 0, 12'o0,   2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_w1",      1, 12'o100, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o100, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_w2",      1, 12'o100, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o100, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_ack",     1, 12'o100, 1, 12'o1234, 0, 0, 12'o0,   0, 0,  1, 1, 12'o100, 2'b01, 12'o0,   0, 0, 0, 0, 12'o0);
    add("slot0_wait",    1, 12'o101, 0, 12'o0,    0, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o0);
    add("slot0_done",    1, 12'o101, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o0);
    add("slot1_done",    1, 12'o101, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 2, 0, 12'o0);
    add("slot2_done",    1, 12'o101, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 3, 0, 12'o0);
    add("slot3_done",    1, 12'o101, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 4, 0, 12'o0);
    add("fetch_next",    1, 12'o101, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o101, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_ack2",    1, 12'o101, 1, 12'o1234, 0, 0, 12'o0,   0, 0,  1, 1, 12'o101, 2'b01, 12'o0,   0, 0, 0, 0, 12'o0);
    add("br_slot0",      1, 12'o102, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o0);
    add("br_slot1",      1, 12'o102, 0, 12'o0,    1, 1, 12'o200, 0, 0,  2, 0, 12'o0,   2'b10, 12'o200, 0, 1, 2, 0, 12'o0);
    add("fetch_tgt",     1, 12'o200, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o200, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_ack3",    1, 12'o200, 1, 12'o1234, 0, 0, 12'o0,   0, 0,  1, 1, 12'o200, 2'b01, 12'o0,   0, 0, 0, 0, 12'o0);
    add("arg_req",       1, 12'o201, 0, 12'o0,    0, 0, 12'o0,   1, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o0);
    add("arg_wait",      1, 12'o201, 0, 12'o0,    0, 0, 12'o0,   0, 0,  3, 1, 12'o201, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("arg_ack",       1, 12'o201, 1, 12'o7777, 0, 0, 12'o0,   0, 0,  3, 1, 12'o201, 2'b01, 12'o0,   0, 0, 0, 0, 12'o0);
    add("arg_pulse",     1, 12'o202, 0, 12'o0,    0, 0, 12'o0,   1, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 1, 12'o7777);
    add("arg_ignored",   1, 12'o202, 0, 12'o0,    0, 0, 12'o0,   1, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o7777);
    add("done_over_arg", 1, 12'o202, 0, 12'o0,    1, 0, 12'o0,   1, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o7777);
    add("halt_slot1",    1, 12'o202, 0, 12'o0,    1, 0, 12'o0,   0, 1,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 2, 0, 12'o7777);
    add("halt_slot2",    1, 12'o202, 0, 12'o0,    1, 0, 12'o0,   0, 1,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 3, 0, 12'o7777);
    add("halt_slot3",    1, 12'o202, 0, 12'o0,    1, 0, 12'o0,   0, 1,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 4, 0, 12'o7777);
    add("halted",        1, 12'o202, 0, 12'o0,    0, 0, 12'o0,   0, 1,  4, 0, 12'o0,   2'b00, 12'o0,   1, 0, 0, 0, 12'o7777);
    add("halt_drop",     1, 12'o202, 0, 12'o0,    0, 0, 12'o0,   0, 0,  4, 0, 12'o0,   2'b00, 12'o0,   1, 0, 0, 0, 12'o7777);
    add("fetch_resume",  1, 12'o202, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o202, 2'b00, 12'o0,   0, 0, 0, 0, 12'o7777);
    add("fetch_ack4",    1, 12'o202, 1, 12'o5000, 0, 0, 12'o0,   0, 0,  1, 1, 12'o202, 2'b01, 12'o0,   0, 0, 0, 0, 12'o7777);
    add("zero_slot0",    1, 12'o203, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 5, 0, 12'o7777);
`ifndef SEQ_ZERO_SKIP_EN
    add("zero_slot1",    1, 12'o203, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 0, 0, 12'o7777);
    add("zero_slot2",    1, 12'o203, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 0, 0, 12'o7777);
    add("zero_slot3",    1, 12'o203, 0, 12'o0,    1, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 0, 0, 12'o7777);
`endif
    add("zero_fetch",    1, 12'o203, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o203, 2'b00, 12'o0,   0, 0, 0, 0, 12'o7777);
    add("fetch_ack5",    1, 12'o203, 1, 12'o1000, 0, 0, 12'o0,   0, 0,  1, 1, 12'o203, 2'b01, 12'o0,   0, 0, 0, 0, 12'o7777);
    add("arg_req2",      1, 12'o204, 0, 12'o0,    0, 0, 12'o0,   1, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o7777);
    add("arg_wait2",     1, 12'o204, 0, 12'o0,    0, 0, 12'o0,   0, 0,  3, 1, 12'o204, 2'b00, 12'o0,   0, 0, 0, 0, 12'o7777);
    split = vecs.size();
    add("rst_hold",      0, 12'o204, 0, 12'o0,    0, 0, 12'o0,   0, 0,  0, 0, 12'o0,   2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("idle_r",        1, 12'o204, 0, 12'o0,    0, 0, 12'o0,   0, 0,  0, 0, 12'o0,   2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_r",       1, 12'o204, 0, 12'o0,    0, 0, 12'o0,   0, 0,  1, 1, 12'o204, 2'b00, 12'o0,   0, 0, 0, 0, 12'o0);
    add("fetch_ack_r",   1, 12'o204, 1, 12'o1234, 0, 0, 12'o0,   0, 0,  1, 1, 12'o204, 2'b01, 12'o0,   0, 0, 0, 0, 12'o0);
    add("slot0_r",       1, 12'o205, 0, 12'o0,    0, 0, 12'o0,   0, 0,  2, 0, 12'o0,   2'b00, 12'o0,   0, 1, 1, 0, 12'o0);

    run_rows(0, split);

    // Asynchronous reset in the middle of an outstanding operand read.
    #1 rst_n = 1'b0;
    #1 check("rst_in_arg", '{st: 3'd0, mreq: 1'b0, maddr: 12'o0, i_f: 2'b00, i_in: 12'o0,
                             regp: 1'b0, opv: 1'b0, op: 3'd0, argv: 1'b0, argd: 12'o0});

    run_rows(split, vecs.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_sequencer.md
IP_SEQUENCER -- requirements
Module: ip_sequencer

Interface
REQ-001 Parameter BOOT_DELAY, default 1: cycles spent in IDLE after reset release before the first FETCH (range 1..15).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 I  in  12  current instruction pointer from the I register.
REQ-005 I_F  out  2  I register function: 00 hold, 01 increment, 10 load I_In.
REQ-006 I_In  out  12  load value for I register.
REQ-007 regP  out  1  I register freeze (1 = I holds regardless of I_F).
REQ-008 mem_req  out  1  memory read request.
REQ-009 mem_addr  out  12  memory read address.
REQ-010 mem_ack  in  1  memory read complete; mem_rdata valid the same cycle.
REQ-011 mem_rdata  in  12  memory read data.
REQ-012 op_valid  out  1  slot opcode presented to execute.
REQ-013 slot_op  out  3  current 3-bit opcode.
REQ-014 exec_done  in  1  execute finished current slot.
REQ-015 branch_take, branch_target  in  1, 12  redirect I on exec_done.
REQ-016 arg_req  in  1  execute needs the next memory word as an operand.
REQ-017 arg_valid, arg_data  out  1, 12  operand pulse and operand value.
REQ-018 halt  in  1  stop at the next word boundary.
REQ-019 seq_state  out  3  FSM state encoding: IDLE 0, FETCH 1, ISSUE 2, ARG 3, HALT 4.

Function
REQ-020 IR is a 12-bit register holding four slots; issue order is IR[11:9], [8:6], [5:3], [2:0]; slot counter is 2 bits.
REQ-021 I_F SHALL be 00 and regP 0 in every cycle not listed in REQ-023, REQ-025 and REQ-026, except HALT, where regP SHALL be 1.
REQ-022 IDLE: count BOOT_DELAY cycles, then go to FETCH; if halt=1 at that point, go to HALT instead.
REQ-023 FETCH: mem_req=1, mem_addr=I; on mem_ack: IR<=mem_rdata, slot<=0, I_F=01 in the same cycle, next state ISSUE.
REQ-024 ISSUE: op_valid=1, slot_op=current slot; zero opcodes are issued like any other (see REQ-033).
REQ-025 ISSUE with exec_done=1: if branch_take, I_F=10 and I_In=branch_target, then go to the word boundary; else if slot=3, go to the word boundary; else slot+1 and stay in ISSUE.
REQ-026 ISSUE with arg_req=1, exec_done=0 and no operand yet delivered for this slot: go to ARG; ARG: mem_req=1, mem_addr=I; on mem_ack: arg_data<=mem_rdata, I_F=01, return to ISSUE, arg_valid=1 for exactly the next cycle.
REQ-027 One operand per slot; arg_req SHALL be ignored after delivery until the slot advances. exec_done takes priority over arg_req in the same cycle.
REQ-028 Word boundary: if halt=1 go to HALT, else go to FETCH. halt has no effect mid-word.
REQ-029 HALT: regP=1, no requests; when halt=0, go to FETCH next cycle.
REQ-030 mem_req, once asserted, SHALL stay asserted with a stable mem_addr until mem_ack; it is never asserted in ISSUE, IDLE or HALT.
REQ-031 A branch in slot 0-2 discards the remaining slots of the word.

Reset
REQ-032 On rst_n=0, immediately: state IDLE, IR=0, slot=0, arg_data=0, arg_valid=0, op_valid=0, mem_req=0, I_F=00, regP=0, I_In=0.

Configuration
REQ-033 SEQ_ZERO_SKIP_EN defined: on exec_done without a branch, if all remaining slots after the current one are 000, go to the word boundary immediately. Undefined: all four slots are issued, including 000.

Verification
REQ-034 Reset, BOOT_DELAY=1, I=12'o100, mem_rdata=12'o1234 with ack after 2 cycles -> FETCH at addr 0100; I_F=01 on the ack cycle; slot_op sequence 1,2,3,4; then FETCH at 0101.
REQ-035 Branch on slot 1, branch_target=12'o200 -> I_F=10 and I_In=0200 in that cycle; slots 2-3 never issued; next mem_addr=0200.
REQ-036 arg_req on slot 0, operand word 12'o7777 -> ARG at addr I; arg_valid is a 1-cycle pulse with arg_data=7777; I is incremented twice in total for the word; slot 1 follows after exec_done.
REQ-037 halt raised during slot 1 -> slots 2-3 are still issued; then HALT with regP=1 and no mem_req; halt dropped -> FETCH next cycle.
REQ-038 IR=12'o5000: with SEQ_ZERO_SKIP_EN, only slot_op 5 is issued, then FETCH; without it, slots 5,0,0,0 are issued.
REQ-039 rst_n asserted during ARG while mem_req=1 -> mem_req and op_valid drop immediately; IDLE; a full fetch proceeds after release.
